// File: rtl/block_reg_mp.sv
// Multi-port register file: NB_READ read ports, two prioritised write ports,
// optional bypass / registered read / hardwired zero, and a sequenced clear sweep.
module block_reg_mp #(
  parameter int SIZE_ADDR_REG = 5,
  parameter int SIZE_REG      = 8,
  parameter int NB_READ       = 2,
  parameter int READ_LAT      = 0,
  parameter int BYPASS        = 1,
  parameter int ZERO_REG      = 0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              charge0,
  input  logic [SIZE_ADDR_REG-1:0]          addr_w0,
  input  logic [SIZE_REG-1:0]               datain0,
  input  logic                              charge1,
  input  logic [SIZE_ADDR_REG-1:0]          addr_w1,
  input  logic [SIZE_REG-1:0]               datain1,
  input  logic [NB_READ*SIZE_ADDR_REG-1:0]  addr_r,
  output logic [NB_READ*SIZE_REG-1:0]       dataout,
  input  logic                              clear,
  output logic                              busy
);

  localparam int DEPTH = 2**SIZE_ADDR_REG;
  localparam logic [SIZE_ADDR_REG-1:0] LAST_PTR = SIZE_ADDR_REG'(DEPTH-1);

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [SIZE_ADDR_REG-1:0]  ptr_q, ptr_d;
  logic [SIZE_REG-1:0]       regs_q [DEPTH];
  logic                      we0_s, we1_s;
  logic [NB_READ*SIZE_REG-1:0] sel_all_s;

  // Clear-sweep sequencer: next state and pointer
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        ptr_d = '0;
        if (clear) state_d = SWEEP;
        else       state_d = IDLE;
      end
      SWEEP: begin
        ptr_d = ptr_q + SIZE_ADDR_REG'(1);
        if (ptr_q == LAST_PTR) state_d = IDLE;
        else                   state_d = SWEEP;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  assign busy = (state_q == SWEEP);

  // Effective write enables: only in IDLE, and never to a hardwired zero register
  always_comb begin
    we0_s = 1'b0;
    we1_s = 1'b0;
    if (state_q == IDLE) begin
      we0_s = charge0 && !((ZERO_REG != 0) && (addr_w0 == '0));
      we1_s = charge1 && !((ZERO_REG != 0) && (addr_w1 == '0));
    end else begin
      we0_s = 1'b0;
      we1_s = 1'b0;
    end
  end

  // Register array; port 1 is applied last so it wins an address collision
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (state_q == SWEEP) begin
      regs_q[ptr_q] <= '0;
    end else begin
      if (we0_s) regs_q[addr_w0] <= datain0;
      if (we1_s) regs_q[addr_w1] <= datain1;
    end
  end

  for (genvar k = 0; k < NB_READ; k++) begin : g_rd
    logic [SIZE_ADDR_REG-1:0] ra_s;
    logic [SIZE_REG-1:0]      sel_s;

    assign ra_s = addr_r[k*SIZE_ADDR_REG +: SIZE_ADDR_REG];

    // Per-port read selection; we*_s already masks bypass during the sweep
    always_comb begin
      sel_s = regs_q[ra_s];
      if ((ZERO_REG != 0) && (ra_s == '0)) begin
        sel_s = '0;
      end else if ((BYPASS != 0) && we1_s && (addr_w1 == ra_s)) begin
        sel_s = datain1;
      end else if ((BYPASS != 0) && we0_s && (addr_w0 == ra_s)) begin
        sel_s = datain0;
      end else begin
        sel_s = regs_q[ra_s];
      end
    end

    assign sel_all_s[k*SIZE_REG +: SIZE_REG] = sel_s;
  end

  if (READ_LAT != 0) begin : g_lat1
    logic [NB_READ*SIZE_REG-1:0] dout_q;

    // Registered read data
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) dout_q <= '0;
      else        dout_q <= sel_all_s;
    end

    assign dataout = dout_q;
  end else begin : g_lat0
    assign dataout = sel_all_s;
  end

endmodule

// File: tb/tb_block_reg_mp.sv
// Scoreboard bench: dut_a = combinational read with bypass, dut_z = registered
// read, no bypass, hardwired zero register; both share the same stimulus.
module tb_block_reg_mp;

  localparam int AW = 5;
  localparam int DW = 8;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            charge0, charge1, clear;
  logic [AW-1:0]   addr_w0, addr_w1;
  logic [DW-1:0]   datain0, datain1;
  logic [NR*AW-1:0] addr_r;
  logic [NR*DW-1:0] dout_a, dout_z;
  logic            busy_a, busy_z;

  always #5 clk = ~clk;

  block_reg_mp #(.SIZE_ADDR_REG(AW), .SIZE_REG(DW), .NB_READ(NR),
                 .READ_LAT(0), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .clk(clk), .reset(reset),
    .charge0(charge0), .addr_w0(addr_w0), .datain0(datain0),
    .charge1(charge1), .addr_w1(addr_w1), .datain1(datain1),
    .addr_r(addr_r), .dataout(dout_a), .clear(clear), .busy(busy_a)
  );

  block_reg_mp #(.SIZE_ADDR_REG(AW), .SIZE_REG(DW), .NB_READ(NR),
                 .READ_LAT(1), .BYPASS(0), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset),
    .charge0(charge0), .addr_w0(addr_w0), .datain0(datain0),
    .charge1(charge1), .addr_w1(addr_w1), .datain1(datain1),
    .addr_r(addr_r), .dataout(dout_z), .clear(clear), .busy(busy_z)
  );

  typedef struct {
    string        name;
    logic [7:0]   e0;
    logic [7:0]   e1;
    logic         eb;
    logic         zc;
    logic [7:0]   z0;
    logic [7:0]   z1;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: compares every pending expectation against the outputs at the falling edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        chk({e.name, ".a0"}, dout_a[7:0],  e.e0);
        chk({e.name, ".a1"}, dout_a[15:8], e.e1);
        chk({e.name, ".busy_a"}, {7'd0, busy_a}, {7'd0, e.eb});
        chk({e.name, ".busy_z"}, {7'd0, busy_z}, {7'd0, e.eb});
        if (e.zc) begin
          chk({e.name, ".z0"}, dout_z[7:0],  e.z0);
          chk({e.name, ".z1"}, dout_z[15:8], e.z1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int c0, input int a0, input int d0,
                       input int c1, input int a1, input int d1,
                       input int r0, input int r1, input int clr);
    charge0 = 1'(c0);  addr_w0 = AW'(a0);  datain0 = DW'(d0);
    charge1 = 1'(c1);  addr_w1 = AW'(a1);  datain1 = DW'(d1);
    addr_r  = {AW'(r1), AW'(r0)};
    clear   = 1'(clr);
  endtask

  task automatic expect_v(input string nm, input int e0, input int e1, input int eb,
                          input int zc, input int z0, input int z1);
    exp_t e;
    e.name = nm;
    e.e0 = 8'(e0);  e.e1 = 8'(e1);  e.eb = 1'(eb);
    e.zc = 1'(zc);  e.z0 = 8'(z0);  e.z1 = 8'(z1);
    sb.push_back(e);
  endtask

  task automatic cyc(input string nm,
                     input int c0, input int a0, input int d0,
                     input int c1, input int a1, input int d1,
                     input int r0, input int r1, input int clr,
                     input int e0, input int e1, input int eb,
                     input int zc, input int z0, input int z1);
    step();
    drive(c0, a0, d0, c1, a1, d1, r0, r1, clr);
    expect_v(nm, e0, e1, eb, zc, z0, z1);
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) step();
    expect_v("rst_hold", 0, 0, 0, 1, 0, 0);
    reset = 1'b1;

    // Prior contents, then asynchronous reset between edges
    cyc("pre_wr",    1, 9, 'hAA, 1, 10, 'h55, 9, 10, 0, 'hAA, 'h55, 0, 1, 0, 0);
    cyc("pre_rd",    0, 0, 0,    0, 0,  0,    9, 10, 0, 'hAA, 'h55, 0, 1, 0, 0);
    cyc("pre_rd_z",  0, 0, 0,    0, 0,  0,    9, 10, 0, 'hAA, 'h55, 0, 1, 'hAA, 'h55);
    step();
    reset = 1'b0;
    #1;
    expect_v("rst_async", 0, 0, 0, 1, 0, 0);
    step();
    reset = 1'b1;

    cyc("wr7",       1, 2, 7,   0, 0,  0,   2, 9,  0, 7,   0,   0, 1, 0,   0);
    cyc("rd7",       0, 0, 0,   0, 0,  0,   2, 2,  0, 7,   7,   0, 1, 0,   0);
    cyc("rd7_z",     0, 0, 0,   0, 0,  0,   2, 2,  0, 7,   7,   0, 1, 7,   7);
    cyc("collide",   1, 5, 3,   1, 5,  250, 5, 2,  0, 250, 7,   0, 1, 7,   7);
    cyc("dual",      1, 4, 11,  1, 30, 124, 5, 4,  0, 250, 11,  0, 1, 0,   7);
    cyc("dual_rd",   0, 0, 0,   0, 0,  0,   4, 30, 0, 11,  124, 0, 1, 250, 0);
    cyc("dual_rd_z", 0, 0, 0,   0, 0,  0,   4, 30, 0, 11,  124, 0, 1, 11,  124);
    cyc("bypass",    1, 2, 250, 0, 0,  0,   4, 2,  0, 11,  250, 0, 1, 11,  124);
    cyc("nobyp_z",   0, 0, 0,   0, 0,  0,   4, 2,  0, 11,  250, 0, 1, 11,  7);
    cyc("idle_byp",  0, 2, 1,   0, 0,  0,   2, 2,  0, 250, 250, 0, 1, 11,  250);
    cyc("zero_wr",   0, 0, 0,   1, 0,  99,  0, 2,  0, 99,  250, 0, 1, 250, 250);
    cyc("zero_rd",   0, 0, 0,   0, 0,  0,   0, 0,  0, 99,  99,  0, 1, 0,   250);
    cyc("zero_rd_z", 0, 0, 0,   0, 0,  0,   0, 2,  0, 99,  250, 0, 1, 0,   0);

    // Fill with index+1 and read back
    for (int i = 0; i < 16; i++) begin
      step();
      drive(1, 2*i, 2*i+1, 1, 2*i+1, 2*i+2, 0, 0, 0);
    end
    for (int i = 0; i < 16; i++)
      cyc("fill_chk", 0, 0, 0, 0, 0, 0, 2*i, 2*i+1, 0, 2*i+1, 2*i+2, 0, 0, 0, 0);

    // Clear sweep: lost writes at cycle 10, clear ignored at cycle 5
    cyc("clr_req", 0, 0, 0, 0, 0, 0, 0, 3, 1, 1, 4, 0, 0, 0, 0);
    for (int j = 0; j < 32; j++)
      cyc("sweep", (j == 10) ? 1 : 0, 3, 55, (j == 10) ? 1 : 0, 10, 77,
          (j == 0) ? 0 : ((j == 10) ? 3 : j-1), j, (j == 5) ? 1 : 0,
          (j == 0) ? 1 : 0, j+1, 1, 0, 0, 0);
    for (int i = 0; i < 16; i++)
      cyc("post_sweep", 0, 0, 0, 0, 0, 0, 2*i, 2*i+1, 0, 0, 0, 0, 0, 0, 0);

    // Reset in the middle of a sweep
    step();
    drive(1, 7, 'h77, 1, 20, 'h20, 0, 0, 0);
    cyc("msw_req", 0, 0, 0, 0, 0, 0, 20, 7, 1, 'h20, 'h77, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++)
      cyc("msw_busy", 0, 0, 0, 0, 0, 0, 20, 7, 0, 'h20, 'h77, 1, 0, 0, 0);
    step();
    reset = 1'b0;
    #1;
    expect_v("msw_rst", 0, 0, 0, 1, 0, 0);
    step();
    reset = 1'b1;
    cyc("msw_post",  0, 0, 0, 0, 0, 0, 20, 7, 0, 0, 0, 0, 1, 0, 0);
    cyc("re_clr",    0, 0, 0, 0, 0, 0, 20, 7, 1, 0, 0, 0, 1, 0, 0);
    for (int j = 0; j < 32; j++)
      cyc("re_busy", 0, 0, 0, 0, 0, 0, 20, 7, 0, 0, 0, 1, 0, 0, 0);
    cyc("re_done",   0, 0, 0, 0, 0, 0, 20, 7, 0, 0, 0, 0, 1, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    n_total++;
    if (sb.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries pending, expected 0", sb.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
